// File: rtl/rocc_sched_pkg.sv
// Shared types for the RoCC command scheduler: unit states, funct codes,
// the buffered command record and the result function.
package rocc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } unit_state_e;

  localparam logic [6:0] FUNCT_ADD = 7'd0;
  localparam logic [6:0] FUNCT_XOR = 7'd1;
  localparam logic [6:0] FUNCT_SUB = 7'd2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [6:0]  funct;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } cmd_t;

  // 64-bit wrapping result; unknown funct codes pass rs1 through.
  function automatic logic [63:0] calc_result(input logic [6:0]  funct,
                                              input logic [63:0] rs1,
                                              input logic [63:0] rs2);
    logic [63:0] res;
    case (funct)
      FUNCT_ADD: res = rs1 + rs2;
      FUNCT_XOR: res = rs1 ^ rs2;
      FUNCT_SUB: res = rs1 - rs2;
      default:   res = rs1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rocc_sched_unit.sv
// One latency-model accelerator unit.
// Ports:
//   clock, reset (async, active-low)
//   start            dispatch strobe, only honoured while IDLE
//   cmd_rd/funct/rs1/rs2  command captured on start
//   ack              response handshake, returns a DONE unit to IDLE
//   idle, done       state flags
//   rd, data         latched destination register and result
module rocc_sched_unit
  import rocc_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  cmd_rd,
  input  logic [6:0]  cmd_funct,
  input  logic [63:0] cmd_rs1,
  input  logic [63:0] cmd_rs2,
  input  logic        ack,
  output logic        idle,
  output logic        done,
  output logic [4:0]  rd,
  output logic [63:0] data
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  unit_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q;
  logic [63:0]     data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CntLoad;
        end
      end
      RUN: begin
        // cnt==0 is the last RUN cycle, giving exactly LATENCY cycles in RUN.
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start && state_q == IDLE) begin
        rd_q   <= cmd_rd;
        data_q <= calc_result(cmd_funct, cmd_rs1, cmd_rs2);
      end
    end
  end

  assign idle = (state_q == IDLE);
  assign done = (state_q == DONE);
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/rocc_cmd_scheduler.sv
// RoCC front-end scheduler: command FIFO, dispatch to the lowest-index idle
// unit, round-robin response arbitration over NUM_UNITS latency-model units.
// Ports:
//   clock, reset (async, active-low)
//   io_cmd_*   RoCC command channel (valid/ready, funct, rd, rs1, rs2)
//   io_resp_*  RoCC response channel (valid/ready, rd, data)
//   io_busy    FIFO non-empty or any unit not idle
// Optional macro SCHED_PERF_CNT_EN adds io_perf_cmds / io_perf_stalls,
// saturating 32-bit counters of accepted commands and stalled offers.
module rocc_cmd_scheduler
  import rocc_sched_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LATENCY    = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [6:0]  io_cmd_bits_inst_funct,
  input  logic [4:0]  io_cmd_bits_inst_rd,
  input  logic [63:0] io_cmd_bits_rs1,
  input  logic [63:0] io_cmd_bits_rs2,
  input  logic        io_resp_ready,
  output logic        io_resp_valid,
  output logic [4:0]  io_resp_bits_rd,
  output logic [63:0] io_resp_bits_data,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0] io_perf_cmds,
  output logic [31:0] io_perf_stalls,
`endif
  output logic        io_busy
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Command FIFO
  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, cmd_push, cmd_pop;
  cmd_t          head;

  // Units
  logic [NUM_UNITS-1:0] unit_idle, unit_done, unit_start, unit_ack;
  logic [4:0]           unit_rd   [NUM_UNITS];
  logic [63:0]          unit_data [NUM_UNITS];
  logic [PtrW-1:0]      disp_idx;

  // Arbiter
  logic [PtrW-1:0] rr_q, grant_idx, lock_idx_q;
  logic            lock_q, grant_found, resp_fire;

  assign fifo_full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Gated by reset so ready reads 0 while reset is held.
  assign io_cmd_ready = reset & ~fifo_full;
  assign cmd_push     = io_cmd_valid & io_cmd_ready;
  assign cmd_pop      = ~fifo_empty & (|unit_idle);
  assign head         = fifo_mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (cmd_push) begin
      fifo_mem[wr_ptr_q] <= '{rd: io_cmd_bits_inst_rd, funct: io_cmd_bits_inst_funct,
                              rs1: io_cmd_bits_rs1, rs2: io_cmd_bits_rs2};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (cmd_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (cmd_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (cmd_push && !cmd_pop)      count_q <= count_q + 1'b1;
      else if (!cmd_push && cmd_pop) count_q <= count_q - 1'b1;
    end
  end

  // Lowest-index idle unit wins dispatch.
  always_comb begin
    disp_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (unit_idle[i]) disp_idx = PtrW'(i);
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    assign unit_start[g] = cmd_pop && (disp_idx == PtrW'(g));
    assign unit_ack[g]   = resp_fire && (grant_idx == PtrW'(g));

    rocc_sched_unit #(
      .LATENCY (LATENCY)
    ) u_unit (
      .clock     (clock),
      .reset     (reset),
      .start     (unit_start[g]),
      .cmd_rd    (head.rd),
      .cmd_funct (head.funct),
      .cmd_rs1   (head.rs1),
      .cmd_rs2   (head.rs2),
      .ack       (unit_ack[g]),
      .idle      (unit_idle[g]),
      .done      (unit_done[g]),
      .rd        (unit_rd[g]),
      .data      (unit_data[g])
    );
  end

  // First DONE unit at or after rr_q. While a response is stalled the grant
  // is locked so a newly finished unit cannot change rd/data under the CPU.
  always_comb begin
    int unsigned     j;
    logic [PtrW-1:0] jj;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    jj          = '0;
    if (lock_q) begin
      grant_found = 1'b1;
      grant_idx   = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        j  = (32'(rr_q) + k) % NUM_UNITS;
        jj = PtrW'(j);
        if (!grant_found && unit_done[jj]) begin
          grant_found = 1'b1;
          grant_idx   = jj;
        end
      end
    end
  end

  assign io_resp_valid     = grant_found;
  assign io_resp_bits_rd   = grant_found ? unit_rd[grant_idx]   : 5'd0;
  assign io_resp_bits_data = grant_found ? unit_data[grant_idx] : 64'd0;
  assign resp_fire         = io_resp_valid & io_resp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (resp_fire) rr_q <= PtrW'((32'(grant_idx) + 32'd1) % NUM_UNITS);
      lock_q     <= io_resp_valid & ~io_resp_ready;
      lock_idx_q <= grant_idx;
    end
  end

  assign io_busy = ~fifo_empty | ~(&unit_idle);

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cmds_q, perf_stalls_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cmds_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (cmd_push && perf_cmds_q != '1) perf_cmds_q <= perf_cmds_q + 1'b1;
      if (io_cmd_valid && !io_cmd_ready && perf_stalls_q != '1) begin
        perf_stalls_q <= perf_stalls_q + 1'b1;
      end
    end
  end

  assign io_perf_cmds   = perf_cmds_q;
  assign io_perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_rocc_cmd_scheduler.sv
// Directed bench for rocc_cmd_scheduler with a response scoreboard.
module tb_rocc_cmd_scheduler;

  localparam int unsigned LAT = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_cmd_valid, io_cmd_ready;
  logic [6:0]  io_cmd_bits_inst_funct;
  logic [4:0]  io_cmd_bits_inst_rd;
  logic [63:0] io_cmd_bits_rs1, io_cmd_bits_rs2;
  logic        io_resp_ready, io_resp_valid;
  logic [4:0]  io_resp_bits_rd;
  logic [63:0] io_resp_bits_data;
  logic        io_busy;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] io_perf_cmds, io_perf_stalls;
  int          exp_cmds = 0;
  int          exp_stalls = 0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] resp_log[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t_acc = 0;
  int         resp_cnt = 0;

  rocc_cmd_scheduler #(
    .NUM_UNITS  (4),
    .FIFO_DEPTH (4),
    .LATENCY    (LAT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_cmd_valid           (io_cmd_valid),
    .io_cmd_ready           (io_cmd_ready),
    .io_cmd_bits_inst_funct (io_cmd_bits_inst_funct),
    .io_cmd_bits_inst_rd    (io_cmd_bits_inst_rd),
    .io_cmd_bits_rs1        (io_cmd_bits_rs1),
    .io_cmd_bits_rs2        (io_cmd_bits_rs2),
    .io_resp_ready          (io_resp_ready),
    .io_resp_valid          (io_resp_valid),
    .io_resp_bits_rd        (io_resp_bits_rd),
    .io_resp_bits_data      (io_resp_bits_data),
`ifdef SCHED_PERF_CNT_EN
    .io_perf_cmds           (io_perf_cmds),
    .io_perf_stalls         (io_perf_stalls),
`endif
    .io_busy                (io_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [6:0] f, input logic [63:0] a,
                                        input logic [63:0] b);
    case (f)
      7'd0:    return a + b;
      7'd1:    return a ^ b;
      7'd2:    return a - b;
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes happen at the posedge following a negedge where valid&&ready.
  always @(negedge clock) begin
    int idx;
    idx = -1;
    if (reset && io_resp_valid && io_resp_ready) begin
      foreach (sb[i]) if (idx < 0 && sb[i].rd == io_resp_bits_rd) idx = i;
      check("resp_expected_rd", 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
        check("resp_data", io_resp_bits_data, sb[idx].data);
        sb.delete(idx);
      end
      resp_log.push_back(io_resp_bits_rd);
      resp_cnt++;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always @(negedge clock) begin
    if (!reset) begin
      exp_cmds   = 0;
      exp_stalls = 0;
    end else begin
      if (io_cmd_valid && io_cmd_ready)  exp_cmds++;
      if (io_cmd_valid && !io_cmd_ready) exp_stalls++;
    end
  end
`endif

  // Called just after a posedge; returns just after the accepting posedge
  // with valid still asserted.
  task automatic send(input logic [6:0] f, input logic [4:0] rd, input logic [63:0] a,
                      input logic [63:0] b);
    int n;
    io_cmd_valid           = 1'b1;
    io_cmd_bits_inst_funct = f;
    io_cmd_bits_inst_rd    = rd;
    io_cmd_bits_rs1        = a;
    io_cmd_bits_rs2        = b;
    n = 0;
    @(negedge clock);
    while (!io_cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("cmd_accept", 64'(io_cmd_ready), 64'd1);
    @(posedge clock);
    #1;
    t_acc = cyc;
    sb.push_back('{rd: rd, data: model(f, a, b)});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || io_busy) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(sb.size() == 0 && !io_busy), 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(io_cmd_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(io_resp_valid), 64'd0);
    check({tag, "_resp_rd"}, 64'(io_resp_bits_rd), 64'd0);
    check({tag, "_resp_data"}, io_resp_bits_data, 64'd0);
    check({tag, "_busy"}, 64'(io_busy), 64'd0);
`ifdef SCHED_PERF_CNT_EN
    check({tag, "_perf_cmds"}, 64'(io_perf_cmds), 64'd0);
    check({tag, "_perf_stalls"}, 64'(io_perf_stalls), 64'd0);
`endif
  endtask

  initial begin
    int          n;
    int          snap;
    logic [4:0]  hold_rd;
    logic [63:0] hold_data;

    reset                  = 1'b0;
    io_cmd_valid           = 1'b0;
    io_cmd_bits_inst_funct = '0;
    io_cmd_bits_inst_rd    = '0;
    io_cmd_bits_rs1        = '0;
    io_cmd_bits_rs2        = '0;
    io_resp_ready          = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst");
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_rst_cmd_ready", 64'(io_cmd_ready), 64'd1);
    @(posedge clock);
    #1;

    // 1: single command latency
    io_resp_ready = 1'b1;
    send(7'd0, 5'd5, 64'd3, 64'd4);
    io_cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!io_resp_valid && n < 50);
    check("t1_latency", 64'(cyc - t_acc), 64'(LAT + 1));
    check("t1_rd", 64'(io_resp_bits_rd), 64'd5);
    @(posedge clock);
    #1;
    check("t1_busy_after", 64'(io_busy), 64'd0);

    // 5: wrap-around arithmetic and other functs
    send(7'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    send(7'd2, 5'd7, 64'd0, 64'd1);
    send(7'd1, 5'd8, 64'hF0F0_0000_1234_5678, 64'h0FF0_FFFF_0000_5678);
    send(7'd9, 5'd9, 64'hDEAD_BEEF_0000_0001, 64'd77);
    io_cmd_valid = 1'b0;
    check("t5_wrap_add_model", sb[0].data, 64'd0);
    check("t5_wrap_sub_model", sb[1].data, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("t5_drain");

    // 2: saturate units and FIFO, 4: backpressure while DONE
    io_resp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(7'(k % 3), 5'(10 + k), 64'(k * 1000 + 1), 64'(k + 7));
    end
    io_cmd_bits_inst_funct = 7'd0;
    io_cmd_bits_inst_rd    = 5'd18;
    io_cmd_bits_rs1        = 64'd100;
    io_cmd_bits_rs2        = 64'd200;
    @(negedge clock);
    check("t2_ninth_ready", 64'(io_cmd_ready), 64'd0);
    n = 0;
    while (!io_resp_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t4_done_seen", 64'(io_resp_valid), 64'd1);
    hold_rd   = io_resp_bits_rd;
    hold_data = io_resp_bits_data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("t4_hold_valid", 64'(io_resp_valid), 64'd1);
      check("t4_hold_rd", 64'(io_resp_bits_rd), 64'(hold_rd));
      check("t4_hold_data", io_resp_bits_data, hold_data);
      check("t4_full_ready", 64'(io_cmd_ready), 64'd0);
    end
    @(posedge clock);
    #1 io_resp_ready = 1'b1;
    send(7'd0, 5'd18, 64'd100, 64'd200);
    io_cmd_valid = 1'b0;
    drain("t2_drain");
    check("t2_resp_count", 64'(resp_cnt), 64'd14);
`ifdef SCHED_PERF_CNT_EN
    check("t2_perf_cmds", 64'(io_perf_cmds), 64'(exp_cmds));
    check("t2_perf_stalls", 64'(io_perf_stalls), 64'(exp_stalls));
    check("t2_perf_stalls_min", 64'(io_perf_stalls >= 32'd20), 64'd1);
`endif

    // 3: simultaneous DONE, round-robin service from rr=0
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    io_resp_ready = 1'b0;
    resp_log.delete();
    send(7'd0, 5'd20, 64'd1, 64'd2);
    send(7'd1, 5'd21, 64'd3, 64'd5);
    send(7'd2, 5'd22, 64'd9, 64'd4);
    io_cmd_valid = 1'b0;
    repeat (LAT + 8) @(posedge clock);
    @(negedge clock);
    check("t3_valid", 64'(io_resp_valid), 64'd1);
    check("t3_first_rd", 64'(io_resp_bits_rd), 64'd20);
    @(posedge clock);
    #1 io_resp_ready = 1'b1;
    drain("t3_drain");
    check("t3_count", 64'(resp_log.size()), 64'd3);
    if (resp_log.size() == 3) begin
      check("t3_order0", 64'(resp_log[0]), 64'd20);
      check("t3_order1", 64'(resp_log[1]), 64'd21);
      check("t3_order2", 64'(resp_log[2]), 64'd22);
    end
    check("t3_rr_ptr", 64'(dut.rr_q), 64'd3);

    // 6: reset during RUN with two queued commands
    for (int k = 0; k < 6; k++) begin
      send(7'd0, 5'(24 + k), 64'(k), 64'd1);
    end
    io_cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clock);
    check_reset_outputs("t6_rst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    snap = resp_cnt;
    repeat (LAT + 20) @(posedge clock);
    #1;
    check("t6_no_resp", 64'(resp_cnt), 64'(snap));
    check("t6_busy", 64'(io_busy), 64'd0);
    check("t6_valid", 64'(io_resp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
